// File: rtl/reg_read_seq_3b.sv
// Burst reader over eight 3-bit registers: select one-hot, capture, present until acked; optional rd_par via READ_PARITY_EN.
// Latency: req edge -> rd_sel next cycle -> rd_valid the cycle after; 2 cycles per further beat after each ack.
// Backpressure: rd_valid/rd_data/rd_addr hold in VALID until ack; req is ignored while busy (no queuing).
module reg_read_seq_3b (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  start_addr,
    input  logic [2:0]  len,
    input  logic [23:0] r_bus,
    input  logic        ack,
    output logic [7:0]  rd_sel,
    output logic [2:0]  rd_addr,
    output logic [2:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef READ_PARITY_EN
    ,
    output logic        rd_par
`endif
);

    typedef enum logic [1:0] {IDLE, SEL, VALID, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cur_addr_q, cur_addr_d;
    logic [2:0]  remaining_q, remaining_d;
    logic [2:0]  rd_addr_q, rd_addr_d;
    logic [2:0]  rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic        req_x, ack_x;
    logic        req_i, ack_i;
    logic [23:0] bus_shift;

    // Unknown inputs are flagged and then treated as 0; synthesis sees constant-known inputs.
`ifdef SYNTHESIS
    assign req_x = 1'b0;
    assign ack_x = 1'b0;
`else
    assign req_x = $isunknown(req);
    assign ack_x = $isunknown(ack);
`endif
    assign req_i = req & ~req_x;
    assign ack_i = ack & ~ack_x;

    assign bus_shift = r_bus >> (5'(cur_addr_q) * 5'd3);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        err_d       = req_x | ack_x | (ack_i & (state_q != VALID));
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    cur_addr_d  = start_addr;
                    remaining_d = len;
                    state_d     = SEL;
                end
            end
            SEL: begin
                rd_data_d = bus_shift[2:0];
                rd_addr_d = cur_addr_q;
                state_d   = VALID;
            end
            VALID: begin
                if (ack_i) begin
                    if (remaining_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        cur_addr_d  = cur_addr_q + 3'd1;
                        remaining_d = remaining_q - 3'd1;
                        state_d     = SEL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= 3'd0;
            remaining_q <= 3'd0;
            rd_addr_q   <= 3'd0;
            rd_data_q   <= 3'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

`ifdef READ_PARITY_EN
    logic rd_par_q, rd_par_d;

    always_comb begin
        rd_par_d = ^rd_data_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_par_q <= 1'b0;
        end else begin
            rd_par_q <= rd_par_d;
        end
    end

    assign rd_par = rd_par_q;
`endif

    assign rd_sel   = (state_q == SEL) ? (8'b0000_0001 << cur_addr_q) : 8'b0;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = (state_q == VALID);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_reg_read_seq_3b.sv
// Directed bench for reg_read_seq_3b: reset, single read, wrap burst, backpressure, protocol errors, mid-burst reset.
module tb_reg_read_seq_3b;

    logic        clk;
    logic        rst;
    logic        req;
    logic [2:0]  start_addr;
    logic [2:0]  len;
    logic [23:0] r_bus;
    logic        ack;
    logic [7:0]  rd_sel;
    logic [2:0]  rd_addr;
    logic [2:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;
`ifdef READ_PARITY_EN
    logic        rd_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    reg_read_seq_3b dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .start_addr (start_addr),
        .len        (len),
        .r_bus      (r_bus),
        .ack        (ack),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef READ_PARITY_EN
        ,
        .rd_par     (rd_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [2:0] val);
        r_bus[3*idx +: 3] = val;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_sel"},   32'(rd_sel),   32'h0);
        chk({tag, ".rd_addr"},  32'(rd_addr),  32'h0);
        chk({tag, ".rd_data"},  32'(rd_data),  32'h0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, ".busy"},     32'(busy),     32'h0);
        chk({tag, ".done"},     32'(done),     32'h0);
        chk({tag, ".err"},      32'(err),      32'h0);
    endtask

    initial begin
        logic [2:0]  exp_addr [4];
        logic [2:0]  exp_data [4];
        logic [23:0] saved_bus;
        int          beats;
        int          last_beat;
        int          done_cnt;
        int          done_cyc;

        rst = 1'b0; req = 1'b0; ack = 1'b0;
        start_addr = 3'd0; len = 3'd0; r_bus = 24'h0;

        // Reset state
        #12;
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk("idle.busy", 32'(busy), 32'h0);

        // Single read of register 2
        set_reg(2, 3'b110);
        req = 1'b1; start_addr = 3'd2; len = 3'd0;
        tick();
        req = 1'b0;
        chk("single.sel", 32'(rd_sel), 32'h04);
        chk("single.busy", 32'(busy), 32'h1);
        chk("single.valid_early", 32'(rd_valid), 32'h0);
        tick();
        chk("single.sel_off", 32'(rd_sel), 32'h00);
        chk("single.valid", 32'(rd_valid), 32'h1);
        chk("single.data", 32'(rd_data), 32'h6);
        chk("single.addr", 32'(rd_addr), 32'h2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("single.done", 32'(done), 32'h1);
        chk("single.valid_done", 32'(rd_valid), 32'h0);
        chk("single.err", 32'(err), 32'h0);
        tick();
        chk("single.done_off", 32'(done), 32'h0);
        chk("single.idle", 32'(busy), 32'h0);

        // Wrap burst 6,7,0,1 with ack held high
        r_bus = 24'h0;
        set_reg(6, 3'b011); set_reg(7, 3'b000); set_reg(0, 3'b111); set_reg(1, 3'b110);
        exp_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_data = '{3'b011, 3'b000, 3'b111, 3'b110};
        req = 1'b1; start_addr = 3'd6; len = 3'd3;
        tick();
        req = 1'b0; ack = 1'b1;
        beats = 0; last_beat = -10; done_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (rd_valid) begin
                if (beats < 4) begin
                    chk($sformatf("wrap.addr%0d", beats), 32'(rd_addr), 32'(exp_addr[beats]));
                    chk($sformatf("wrap.data%0d", beats), 32'(rd_data), 32'(exp_data[beats]));
`ifdef READ_PARITY_EN
                    chk($sformatf("wrap.par%0d", beats), 32'(rd_par), 32'(^exp_data[beats]));
`endif
                    if (beats > 0)
                        chk($sformatf("wrap.gap%0d", beats), 32'(c - last_beat), 32'd2);
                end
                beats++;
                last_beat = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        ack = 1'b0;
        tick();
        chk("wrap.beats", 32'(beats), 32'd4);
        chk("wrap.done_cnt", 32'(done_cnt), 32'd1);
        chk("wrap.done_pos", 32'(done_cyc), 32'(last_beat + 1));
        chk("wrap.idle", 32'(busy), 32'h0);

        // Backpressure: hold 5 cycles, r_bus churn and req while busy ignored
        r_bus = 24'h0;
        set_reg(3, 3'b101); set_reg(4, 3'b010);
        saved_bus = r_bus;
        req = 1'b1; start_addr = 3'd3; len = 3'd1;
        tick();
        req = 1'b0;
        tick();
        chk("bp.data", 32'(rd_data), 32'h5);
        chk("bp.addr", 32'(rd_addr), 32'h3);
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; start_addr = 3'd0; len = 3'd7;
            r_bus = r_bus ^ 24'hFFFFFF;
            tick();
            chk($sformatf("bp.hold_valid%0d", i), 32'(rd_valid), 32'h1);
            chk($sformatf("bp.hold_data%0d", i), 32'(rd_data), 32'h5);
            chk($sformatf("bp.hold_addr%0d", i), 32'(rd_addr), 32'h3);
        end
        req = 1'b0;
        r_bus = saved_bus;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("bp.sel2", 32'(rd_sel), 32'h10);
        chk("bp.valid_sel", 32'(rd_valid), 32'h0);
        tick();
        chk("bp.addr2", 32'(rd_addr), 32'h4);
        chk("bp.data2", 32'(rd_data), 32'h2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("bp.done", 32'(done), 32'h1);
        tick();
        chk("bp.idle", 32'(busy), 32'h0);

        // Protocol error: ack in IDLE
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("perr.err", 32'(err), 32'h1);
        chk("perr.busy", 32'(busy), 32'h0);
        tick();
        chk("perr.err_off", 32'(err), 32'h0);

        // Reset mid-burst, then req held through reset starts on first edge
        set_reg(5, 3'b101);
        req = 1'b1; start_addr = 3'd5; len = 3'd2;
        tick();
        req = 1'b0;
        tick();
        chk("mid.data", 32'(rd_data), 32'h5);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("mid.rst");
        req = 1'b1; start_addr = 3'd1; len = 3'd0;
        set_reg(1, 3'b011);
        tick();
        chk("mid.done_held", 32'(done), 32'h0);
        chk("mid.busy_held", 32'(busy), 32'h0);
        #2;
        rst = 1'b1;
        tick();
        req = 1'b0;
        chk("mid.restart_sel", 32'(rd_sel), 32'h02);
        tick();
        chk("mid.restart_data", 32'(rd_data), 32'h3);
        chk("mid.restart_addr", 32'(rd_addr), 32'h1);
`ifdef READ_PARITY_EN
        chk("mid.par", 32'(rd_par), 32'h0);
`endif
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mid.done", 32'(done), 32'h1);
        tick();
        chk("mid.idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
